// File: rtl/exeu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exeu_seq_pkg
// Description : Shared parameters for the execute-unit sequencer: sequencer
//               state encoding, latency field default and the dynamic
//               instruction constants used by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package exeu_seq_pkg;

    // Default width of the iterative-unit latency field
    localparam int c_LAT_WIDTH_DEFAULT = 6;

    // Dynamic-instruction constants
    localparam int c_ALU_LATENCY  = 1;  // single-cycle ops finish one cycle after issue
    localparam int c_INSTRET_STEP = 1;  // retired-instruction counter increment

    // Sequencer state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } exeu_state_e;

endpackage : exeu_seq_pkg
`default_nettype wire

// File: rtl/exeu_seq.sv
`default_nettype none
// ============================================================================
// Module      : exeu_seq
// Description : Execute-unit sequencer. Accepts one decoded instruction at a
//               time, counts down its execution latency, raises the IFU
//               redirect for taken control transfers, offers the writeback
//               and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module exeu_seq
    import exeu_seq_pkg::*;
#(
    parameter int LAT_WIDTH      = c_LAT_WIDTH_DEFAULT,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // decode side
    input  logic                      id_valid_i,
    output logic                      id_ready_o,
    input  logic                      id_multi_i,
    input  logic [LAT_WIDTH-1:0]      id_lat_i,
    input  logic                      id_ctrl_i,
    input  logic                      id_wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    // datapath control
    output logic                      ex_issue_o,
    output logic                      ex_hold_o,
    input  logic                      ex_redirect_i,
    output logic                      ifu_redirect_o,
    input  logic                      flush_i,
    // writeback / retire
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
    output logic                      retire_o,
    output logic [CNT_WIDTH-1:0]      instret_o
);

    localparam logic [LAT_WIDTH-1:0] c_CNT_ONE = LAT_WIDTH'(c_ALU_LATENCY);

    exeu_state_e               r_state;
    logic [LAT_WIDTH-1:0]      r_cnt;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_wb_en;
    logic                      r_ctrl;
    logic [CNT_WIDTH-1:0]      r_instret;

    logic                      w_idle;
    logic                      w_busy;
    logic                      w_wb;
    logic                      w_accept;
    logic                      w_result;
    logic                      w_retire;
    logic [LAT_WIDTH-1:0]      w_cnt_load;

    assign w_idle   = (r_state == S_IDLE);
    assign w_busy   = (r_state == S_BUSY);
    assign w_wb     = (r_state == S_WB);

    // Reset and flush both close the intake so nothing is accepted in those cycles
    assign id_ready_o = w_idle & ~flush_i & ~rst;
    assign w_accept   = id_valid_i & id_ready_o;
    assign w_result   = w_busy & (r_cnt == c_CNT_ONE);

    // A zero latency, or a non-iterative op, behaves as a single-cycle op
    assign w_cnt_load = (id_multi_i && (id_lat_i != '0)) ? id_lat_i : c_CNT_ONE;

    // Retire either straight from the result cycle (no rd) or on the writeback handshake;
    // a flush in the same cycle cancels both.
    assign w_retire = ~rst & ~flush_i &
                      ((w_result & ~r_wb_en) | (w_wb & wb_ready_i));

    assign ex_issue_o     = w_accept;
    assign ex_hold_o      = w_busy | w_wb;
    assign ifu_redirect_o = ~rst & w_result & r_ctrl & ex_redirect_i & ~flush_i;
    assign wb_valid_o     = ~rst & w_wb;
    assign wb_rd_o        = w_wb ? r_rd : '0;
    assign retire_o       = w_retire;
    assign instret_o      = r_instret;

    // Sequencer FSM, latency counter, latched instruction fields and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_ctrl    <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNT_WIDTH'(c_INSTRET_STEP);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd    <= id_rd_i;
                        r_wb_en <= id_wb_en_i;
                        r_ctrl  <= id_ctrl_i;
                        r_cnt   <= w_cnt_load;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (w_result) begin
                            r_state <= r_wb_en ? S_WB : S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    // wb_rd_o stays on r_rd until the handshake or a flush
                    if (flush_i || wb_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : exeu_seq
`default_nettype wire

// File: tb/tb_exeu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exeu_seq
// Description : Self-checking bench for exeu_seq (CNT_WIDTH=4 build).
//               Expected writebacks are queued when an instruction is offered
//               and popped when the sequencer presents the writeback/retire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exeu_seq;

    localparam int LAT_WIDTH      = 6;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CNT_WIDTH      = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid_i;
    logic                      id_ready_o;
    logic                      id_multi_i;
    logic [LAT_WIDTH-1:0]      id_lat_i;
    logic                      id_ctrl_i;
    logic                      id_wb_en_i;
    logic [REG_ADDR_WIDTH-1:0] id_rd_i;
    logic                      ex_issue_o;
    logic                      ex_hold_o;
    logic                      ex_redirect_i;
    logic                      ifu_redirect_o;
    logic                      flush_i;
    logic                      wb_valid_o;
    logic                      wb_ready_i;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_o;
    logic                      retire_o;
    logic [CNT_WIDTH-1:0]      instret_o;

    typedef struct packed {
        logic                      wb_en;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } exp_t;

    exp_t                 sb[$];
    int                   n_checks = 0;
    int                   n_fail   = 0;
    logic [CNT_WIDTH-1:0] exp_instret;

    always #5 clk = ~clk;

    exeu_seq #(
        .LAT_WIDTH      (LAT_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_ready_o     (id_ready_o),
        .id_multi_i     (id_multi_i),
        .id_lat_i       (id_lat_i),
        .id_ctrl_i      (id_ctrl_i),
        .id_wb_en_i     (id_wb_en_i),
        .id_rd_i        (id_rd_i),
        .ex_issue_o     (ex_issue_o),
        .ex_hold_o      (ex_hold_o),
        .ex_redirect_i  (ex_redirect_i),
        .ifu_redirect_o (ifu_redirect_o),
        .flush_i        (flush_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_rd_o        (wb_rd_o),
        .retire_o       (retire_o),
        .instret_o      (instret_o)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        id_valid_i = 1'b0;
        id_multi_i = 1'b0;
        id_lat_i   = '0;
        id_ctrl_i  = 1'b0;
        id_wb_en_i = 1'b0;
        id_rd_i    = '0;
    endtask

    task automatic offer(input logic multi, input logic [LAT_WIDTH-1:0] lat, input logic ctrl,
                         input logic wb_en, input logic [REG_ADDR_WIDTH-1:0] rd);
        exp_t e;
        id_valid_i = 1'b1;
        id_multi_i = multi;
        id_lat_i   = lat;
        id_ctrl_i  = ctrl;
        id_wb_en_i = wb_en;
        id_rd_i    = rd;
        e.wb_en    = wb_en;
        e.rd       = rd;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        to_drive();
        rst = 1'b1;
        id_valid_i = 1'b1;
        to_sample();
        n_checks++;
        if ({id_ready_o, ex_issue_o, ifu_redirect_o, wb_valid_o, retire_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/issue/redir/wbv/retire=%b expected 00000",
                     {id_ready_o, ex_issue_o, ifu_redirect_o, wb_valid_o, retire_o});
        end
        to_drive();
        rst = 1'b0;
        drive_idle();
        to_sample();
        n_checks++;
        if (id_ready_o !== 1'b1 || ex_hold_o !== 1'b0 || instret_o !== 4'd0 || wb_rd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b hold=%b instret=%0d wb_rd=%0d expected 1 0 0 0",
                     id_ready_o, ex_hold_o, instret_o, wb_rd_o);
        end
        exp_instret = '0;
    endtask

    task automatic test_single_alu();
        exp_t e;
        to_drive();
        wb_ready_i = 1'b1;
        offer(1'b0, 6'd0, 1'b0, 1'b1, 5'd5);
        to_sample();
        n_checks++;
        if (ex_issue_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: ex_issue_o=%b expected 1", ex_issue_o);
        end
        to_drive();
        drive_idle();
        to_sample();
        n_checks++;
        if ({ex_hold_o, id_ready_o, wb_valid_o, retire_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_result: hold/ready/wbv/retire=%b expected 1000",
                     {ex_hold_o, id_ready_o, wb_valid_o, retire_o});
        end
        to_drive();
        to_sample();
        e = sb.pop_front();
        n_checks++;
        if (wb_valid_o !== 1'b1 || retire_o !== 1'b1 || wb_rd_o !== e.rd) begin
            n_fail++;
            $display("FAIL single_wb: wbv=%b retire=%b wb_rd=%0d expected 1 1 %0d",
                     wb_valid_o, retire_o, wb_rd_o, e.rd);
        end
        exp_instret++;
        to_drive();
        to_sample();
        n_checks++;
        if (instret_o !== exp_instret || id_ready_o !== 1'b1 || wb_rd_o !== 5'd0) begin
            n_fail++;
            $display("FAIL single_after: instret=%0d ready=%b wb_rd=%0d expected %0d 1 0",
                     instret_o, id_ready_o, wb_rd_o, exp_instret);
        end
    endtask

    task automatic test_multi();
        exp_t e;
        // latency 4: result cycle at T+4, writeback at T+5
        to_drive();
        wb_ready_i = 1'b1;
        offer(1'b1, 6'd4, 1'b0, 1'b1, 5'd9);
        to_sample();
        n_checks++;
        if (ex_issue_o !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_issue: ex_issue_o=%b expected 1", ex_issue_o);
        end
        for (int k = 1; k <= 5; k++) begin
            to_drive();
            drive_idle();
            to_sample();
            n_checks++;
            if (id_ready_o !== 1'b0 || ex_hold_o !== 1'b1 || wb_valid_o !== (k == 5) ||
                retire_o !== (k == 5)) begin
                n_fail++;
                $display("FAIL multi_cycle%0d: ready=%b hold=%b wbv=%b retire=%b expected 0 1 %0d %0d",
                         k, id_ready_o, ex_hold_o, wb_valid_o, retire_o, (k == 5), (k == 5));
            end
            if (k == 5) begin
                e = sb.pop_front();
                n_checks++;
                if (wb_rd_o !== e.rd) begin
                    n_fail++;
                    $display("FAIL multi_rd: wb_rd=%0d expected %0d", wb_rd_o, e.rd);
                end
                exp_instret++;
            end
        end
        to_drive();
        to_sample();
        n_checks++;
        if (id_ready_o !== 1'b1 || instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL multi_after: ready=%b instret=%0d expected 1 %0d", id_ready_o, instret_o, exp_instret);
        end
        // latency 0 on the iterative unit behaves as latency 1
        to_drive();
        offer(1'b1, 6'd0, 1'b0, 1'b1, 5'd22);
        to_sample();
        to_drive();
        drive_idle();
        to_sample();
        n_checks++;
        if (wb_valid_o !== 1'b0 || ex_hold_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lat0_result: wbv=%b hold=%b expected 0 1", wb_valid_o, ex_hold_o);
        end
        to_drive();
        to_sample();
        e = sb.pop_front();
        n_checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== e.rd || retire_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lat0_wb: wbv=%b wb_rd=%0d retire=%b expected 1 %0d 1", wb_valid_o, wb_rd_o, retire_o, e.rd);
        end
        exp_instret++;
    endtask

    task automatic test_branch();
        to_drive();
        ex_redirect_i = 1'b1;
        offer(1'b0, 6'd0, 1'b1, 1'b0, 5'd0);
        to_sample();
        n_checks++;
        if (ex_issue_o !== 1'b1 || ifu_redirect_o !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_issue: issue=%b redir=%b expected 1 0", ex_issue_o, ifu_redirect_o);
        end
        to_drive();
        drive_idle();
        to_sample();
        void'(sb.pop_front());
        n_checks++;
        if (ifu_redirect_o !== 1'b1 || retire_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_result: redir=%b retire=%b wbv=%b expected 1 1 0",
                     ifu_redirect_o, retire_o, wb_valid_o);
        end
        exp_instret++;
        to_drive();
        to_sample();
        n_checks++;
        if (ifu_redirect_o !== 1'b0 || retire_o !== 1'b0 || id_ready_o !== 1'b1 || instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL branch_after: redir=%b retire=%b ready=%b instret=%0d expected 0 0 1 %0d",
                     ifu_redirect_o, retire_o, id_ready_o, instret_o, exp_instret);
        end
        ex_redirect_i = 1'b0;
    endtask

    task automatic test_wb_stall();
        exp_t e;
        to_drive();
        wb_ready_i = 1'b0;
        offer(1'b0, 6'd0, 1'b0, 1'b1, 5'd17);
        to_sample();
        to_drive();
        drive_idle();
        to_sample();
        e = sb.pop_front();
        for (int k = 1; k <= 4; k++) begin
            to_drive();
            wb_ready_i = (k == 4);
            to_sample();
            n_checks++;
            if (wb_valid_o !== 1'b1 || wb_rd_o !== e.rd || retire_o !== (k == 4)) begin
                n_fail++;
                $display("FAIL stall_wb%0d: wbv=%b wb_rd=%0d retire=%b expected 1 %0d %0d",
                         k, wb_valid_o, wb_rd_o, retire_o, e.rd, (k == 4));
            end
        end
        exp_instret++;
        to_drive();
        to_sample();
        n_checks++;
        if (wb_valid_o !== 1'b0 || retire_o !== 1'b0 || id_ready_o !== 1'b1 || instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL stall_after: wbv=%b retire=%b ready=%b instret=%0d expected 0 0 1 %0d",
                     wb_valid_o, retire_o, id_ready_o, instret_o, exp_instret);
        end
    endtask

    task automatic test_flush();
        // flush at the result cycle of a taken jal
        to_drive();
        wb_ready_i    = 1'b1;
        ex_redirect_i = 1'b1;
        offer(1'b0, 6'd0, 1'b1, 1'b1, 5'd1);
        to_sample();
        void'(sb.pop_front());
        to_drive();
        drive_idle();
        flush_i = 1'b1;
        to_sample();
        n_checks++;
        if (ifu_redirect_o !== 1'b0 || retire_o !== 1'b0 || id_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_jal: redir=%b retire=%b ready=%b expected 0 0 0", ifu_redirect_o, retire_o, id_ready_o);
        end
        to_drive();
        flush_i       = 1'b0;
        ex_redirect_i = 1'b0;
        to_sample();
        n_checks++;
        if (id_ready_o !== 1'b1 || wb_valid_o !== 1'b0 || ex_hold_o !== 1'b0 || instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL flush_jal_after: ready=%b wbv=%b hold=%b instret=%0d expected 1 0 0 %0d",
                     id_ready_o, wb_valid_o, ex_hold_o, instret_o, exp_instret);
        end
        // flush during WB: valid still shown, handshake ignored
        to_drive();
        offer(1'b0, 6'd0, 1'b0, 1'b1, 5'd3);
        to_sample();
        void'(sb.pop_front());
        to_drive();
        drive_idle();
        to_sample();
        to_drive();
        flush_i = 1'b1;
        to_sample();
        n_checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd3 || retire_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wb: wbv=%b wb_rd=%0d retire=%b expected 1 3 0", wb_valid_o, wb_rd_o, retire_o);
        end
        to_drive();
        flush_i = 1'b0;
        to_sample();
        n_checks++;
        if (id_ready_o !== 1'b1 || wb_valid_o !== 1'b0 || instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL flush_wb_after: ready=%b wbv=%b instret=%0d expected 1 0 %0d",
                     id_ready_o, wb_valid_o, instret_o, exp_instret);
        end
        // flush together with a valid instruction in IDLE: no accept
        to_drive();
        flush_i    = 1'b1;
        id_valid_i = 1'b1;
        id_wb_en_i = 1'b1;
        id_rd_i    = 5'd4;
        to_sample();
        n_checks++;
        if (ex_issue_o !== 1'b0 || id_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: issue=%b ready=%b expected 0 0", ex_issue_o, id_ready_o);
        end
        to_drive();
        flush_i = 1'b0;
        drive_idle();
        to_sample();
        n_checks++;
        if (ex_hold_o !== 1'b0 || id_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle_after: hold=%b ready=%b expected 0 1", ex_hold_o, id_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   eff;
        bit   seen;
        logic [LAT_WIDTH-1:0]      lat;
        logic [REG_ADDR_WIDTH-1:0] rd;
        wb_ready_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            lat = LAT_WIDTH'($urandom_range(0, 5));
            rd  = REG_ADDR_WIDTH'($urandom_range(1, 31));
            eff = (lat == '0) ? 1 : int'(lat);
            to_drive();
            offer(1'b1, lat, 1'b0, 1'b1, rd);
            to_sample();
            n_checks++;
            if (ex_issue_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_issue%0d: ex_issue_o=%b expected 1", n, ex_issue_o);
            end
            seen = 1'b0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                to_drive();
                drive_idle();
                to_sample();
                if (wb_valid_o === 1'b1) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    n_checks++;
                    if (c != eff + 1 || wb_rd_o !== e.rd || retire_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_wb%0d: cycle=%0d wb_rd=%0d retire=%b expected %0d %0d 1",
                                 n, c, wb_rd_o, retire_o, eff + 1, e.rd);
                    end
                    exp_instret++;
                end
            end
            if (!seen) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_timeout%0d: wb_valid_o=0 after 20 cycles expected 1", n);
                void'(sb.pop_front());
            end
        end
        to_drive();
        to_sample();
        n_checks++;
        if (instret_o !== exp_instret) begin
            n_fail++;
            $display("FAIL b2b_instret: instret=%0d expected %0d", instret_o, exp_instret);
        end
    endtask

    task automatic test_wrap_and_reset();
        to_drive();
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        exp_instret = '0;
        for (int i = 0; i < 16; i++) begin
            to_drive();
            offer(1'b0, 6'd0, 1'b0, 1'b0, 5'd0);
            to_sample();
            to_drive();
            drive_idle();
            to_sample();
            void'(sb.pop_front());
            n_checks++;
            if (retire_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_retire%0d: retire=%b expected 1", i, retire_o);
            end
            to_drive();
            to_sample();
            if (i == 14) begin
                n_checks++;
                if (instret_o !== 4'd15) begin
                    n_fail++;
                    $display("FAIL wrap_allones: instret=%0d expected 15", instret_o);
                end
            end
            if (i == 15) begin
                n_checks++;
                if (instret_o !== 4'd0) begin
                    n_fail++;
                    $display("FAIL wrap_zero: instret=%0d expected 0", instret_o);
                end
            end
        end
        // reset while an iterative op is busy
        to_drive();
        offer(1'b1, 6'd5, 1'b0, 1'b1, 5'd8);
        to_sample();
        void'(sb.pop_front());
        to_drive();
        drive_idle();
        to_sample();
        to_drive();
        rst        = 1'b1;
        id_valid_i = 1'b1;
        to_sample();
        n_checks++;
        if ({id_ready_o, ex_issue_o, wb_valid_o, retire_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_busy: ready/issue/wbv/retire=%b expected 0000",
                     {id_ready_o, ex_issue_o, wb_valid_o, retire_o});
        end
        to_drive();
        rst = 1'b0;
        drive_idle();
        to_sample();
        n_checks++;
        if (id_ready_o !== 1'b1 || ex_hold_o !== 1'b0 || instret_o !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_busy_after: ready=%b hold=%b instret=%0d expected 1 0 0", id_ready_o, ex_hold_o, instret_o);
        end
        for (int k = 0; k < 6; k++) begin
            to_drive();
            to_sample();
            n_checks++;
            if (retire_o !== 1'b0 || wb_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_abandon%0d: retire=%b wbv=%b expected 0 0", k, retire_o, wb_valid_o);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        ex_redirect_i = 1'b0;
        wb_ready_i    = 1'b0;
        exp_instret   = '0;
        drive_idle();
        test_reset();
        test_single_alu();
        test_multi();
        test_branch();
        test_wb_stall();
        test_flush();
        test_back_to_back();
        test_wrap_and_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_exeu_seq
`default_nettype wire

// File: doc/exeu_seq.md
EXEU_SEQ -- requirements
Module: exeu_seq

Interface
REQ-001 Parameter LAT_WIDTH, default 6, SHALL set the multi-cycle latency field width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, SHALL set the destination register index width.
REQ-003 Parameter CNT_WIDTH, default 32, SHALL set the retire counter width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_valid_i  in  1  IDU offers a decoded instruction.
REQ-008 id_ready_o  out  1  sequencer can accept an instruction this cycle.
REQ-009 id_multi_i  in  1  instruction uses the iterative unit.
REQ-010 id_lat_i  in  LAT_WIDTH  iterative-unit latency in cycles.
REQ-011 id_ctrl_i  in  1  instruction is a branch, jal or jalr.
REQ-012 id_wb_en_i  in  1  instruction writes rd.
REQ-013 id_rd_i  in  REG_ADDR_WIDTH  destination register index.
REQ-014 ex_issue_o  out  1  pulse: datapath latches operands.
REQ-015 ex_hold_o  out  1  datapath holds its operand/result registers.
REQ-016 ex_redirect_i  in  1  datapath decides to take the PC target.
REQ-017 ifu_redirect_o  out  1  pulse: IFU loads the actual target.
REQ-018 flush_i  in  1  abort the in-flight instruction.
REQ-019 wb_valid_o  out  1  writeback is offered.
REQ-020 wb_ready_i  in  1  regfile accepts the writeback.
REQ-021 wb_rd_o  out  REG_ADDR_WIDTH  writeback register index.
REQ-022 retire_o  out  1  pulse: instruction completed.
REQ-023 instret_o  out  CNT_WIDTH  retired instruction count.

Function
REQ-024 The FSM SHALL have exactly three states: IDLE, BUSY and WB.
REQ-025 id_ready_o SHALL be 1 only when the state is IDLE and flush_i=0.
REQ-026 The block SHALL accept an instruction in any cycle where id_valid_i and id_ready_o are both 1.
REQ-027 ex_issue_o SHALL be asserted combinationally in the accept cycle.
REQ-028 On accept, the block SHALL latch rd, wb_en and ctrl, and go to BUSY.
REQ-029 On accept, cnt SHALL load id_lat_i when id_multi_i=1 and id_lat_i>=1, and SHALL load 1 otherwise (a latency of 0 is treated as 1).
REQ-030 In BUSY, cnt SHALL decrement each cycle, and the cycle with cnt==1 is the result cycle.
REQ-031 ifu_redirect_o SHALL equal (BUSY & cnt==1 & ctrl & ex_redirect_i & !flush_i).
REQ-032 ifu_redirect_o SHALL never be asserted in any other cycle.
REQ-033 After the result cycle, the FSM SHALL go to WB when wb_en=1.
REQ-034 After the result cycle, when wb_en=0 the FSM SHALL go to IDLE and pulse retire_o in the result cycle.
REQ-035 In WB, wb_valid_o SHALL be 1 and wb_rd_o SHALL hold the latched rd.
REQ-036 On wb_valid_o & wb_ready_i, the block SHALL pulse retire_o and go to IDLE.
REQ-037 wb_valid_o, once asserted, SHALL hold with a stable wb_rd_o until the handshake completes or a flush occurs.
REQ-038 ex_hold_o SHALL be 1 in BUSY and WB.
REQ-039 Minimum latency: accept at T, result cycle at T+1, wb_valid_o at T+2.
REQ-040 Accept-to-result SHALL take cnt cycles, with at most one instruction in flight.
REQ-041 flush_i in BUSY or WB SHALL force the FSM to IDLE next cycle, with no retire_o and no ifu_redirect_o.
REQ-042 flush_i in WB SHALL still allow wb_valid_o in that cycle, but a handshake in that cycle SHALL be ignored.
REQ-043 flush_i and id_valid_i together in IDLE SHALL result in no accept.
REQ-044 instret_o SHALL increment by 1 on each retire_o.
REQ-045 instret_o SHALL wrap from all-ones to 0.
REQ-046 wb_rd_o SHALL be 0 outside WB.

Reset
REQ-047 rst=1 at a clock edge SHALL force IDLE, cnt=0, latched rd/wb_en/ctrl=0 and instret_o=0.
REQ-048 During reset, all pulse and valid outputs (ex_issue_o, ifu_redirect_o, wb_valid_o, retire_o) SHALL be 0.
REQ-049 Reset mid-operation SHALL abandon the instruction with no retire.
REQ-050 id_ready_o SHALL be 0 while rst=1.

Structure
REQ-051 The state encoding (IDLE/BUSY/WB) and the LAT_WIDTH default SHALL live in the shared params header alongside the existing dynamic-instruction constants.
REQ-052 No sub-module SHALL be used; the counter and FSM stay inline.

Verification
REQ-053 The bench SHALL cover: single-cycle ALU op, wb_en=1, rd=5, wb_ready_i=1 -> issue at T, wb_valid_o at T+2 with wb_rd_o=5, retire_o at T+2, instret_o=1.
REQ-054 The bench SHALL cover: multi op with id_lat_i=4 -> result cycle at T+4, wb_valid_o at T+5, id_ready_o=0 from T+1 to T+5.
REQ-055 The bench SHALL cover: taken branch (ctrl=1, wb_en=0, ex_redirect_i=1) -> ifu_redirect_o for one cycle at T+1, retire_o at T+1, IDLE at T+2.
REQ-056 The bench SHALL cover: wb_ready_i held 0 for 3 cycles in WB -> wb_valid_o and wb_rd_o stable, a single retire_o on the 4th cycle.
REQ-057 The bench SHALL cover: flush_i at the result cycle of a taken jal -> no redirect, no retire, instret_o unchanged, id_ready_o=1 next cycle.
REQ-058 The bench SHALL cover: instret_o preset to all-ones via 2^CNT_WIDTH-1 retires (CNT_WIDTH=4 build) plus one more -> instret_o=0; rst during BUSY -> IDLE next cycle.
